add_layer_sched: RTL

//  Scheduler for one element-wise ADD layer. Accepts a decoded ADD instruction, configures and starts
//  the two operand input address generators (operand A, operand B) with a common start pulse, and

---
 rtl/add_layer_sched_pkg.sv | 21 ++
 rtl/add_layer_sched_wb_pipe.sv | 73 +++++++
 rtl/add_layer_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/add_layer_sched_pkg.sv
// Shared definitions for the ADD-layer scheduler: state encoding, default widths
// and the opcode value the decoder uses for element-wise ADD.
package add_layer_sched_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DIM_W_DEF  = 8;
    localparam int CNT_W_DEF  = 3 * DIM_W_DEF;
    localparam int RD_LAT_DEF = 4;

    localparam logic [3:0] ADD_MODE = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/add_layer_sched_wb_pipe.sv
// Write-back side of the ADD scheduler: a valid shift register that delays each
// joint read beat by RD_LAT cycles, plus the wrapping result address counter.
module add_wb_pipe #(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_beat,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_drain_ok
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] shift_in;
    logic [ADDR_W-1:0] addr_q, addr_d;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign shift_in[gi] = i_beat;
            end else begin : g_body
                assign shift_in[gi] = vld_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        vld_d = shift_in;
        if (i_flush || i_load) begin
            vld_d = '0;
        end
    end

    assign o_wr_en = vld_q[RD_LAT-1];

    always_comb begin
        addr_d = addr_q;
        if (i_load) begin
            addr_d = i_load_addr;
        end else if (o_wr_en) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    assign o_wr_addr = addr_q;

    // Safe to leave DRAIN once only the last two stages can hold a beat: the
    // final write then lands in the same cycle as the done pulse.
    generate
        if (RD_LAT > 2) begin : g_drain_deep
            assign o_drain_ok = ~|vld_q[RD_LAT-3:0];
        end else begin : g_drain_short
            assign o_drain_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/add_layer_sched.sv
// Element-wise ADD layer scheduler: accepts one decoded instruction, starts both
// operand address generators, counts joint read beats and drives result write-back.
module add_layer_sched
    import add_layer_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_o,
    input  logic [DIM_W-1:0]  i_out_x_length,
    input  logic [DIM_W-1:0]  i_out_y_length,
    input  logic [DIM_W-1:0]  i_in_piece,
    output logic              o_start_calc,
    output logic [ADDR_W-1:0] o_addr_start_a,
    output logic [ADDR_W-1:0] o_addr_start_b,
    output logic [DIM_W-1:0]  o_out_x_length,
    output logic [DIM_W-1:0]  o_out_y_length,
    output logic [DIM_W-1:0]  o_in_piece,
    input  logic              i_rd_en_a,
    input  logic              i_rd_en_b,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DIM_W-1:0]  x_q, x_d;
    logic [DIM_W-1:0]  y_q, y_d;
    logic [DIM_W-1:0]  piece_q, piece_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic accept;
    logic beat;
    logic mismatch;
    logic flush;
    logic drain_ok;

    always_comb begin
        state_d    = state_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        x_d        = x_q;
        y_d        = y_q;
        piece_d    = piece_q;
        total_d    = total_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        accept     = 1'b0;
        beat       = 1'b0;
        mismatch   = 1'b0;
        flush      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_instr_valid) begin
                    accept     = 1'b1;
                    addr_a_d   = i_addr_a;
                    addr_b_d   = i_addr_b;
                    x_d        = i_out_x_length;
                    y_d        = i_out_y_length;
                    piece_d    = i_in_piece;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (x_q == '0 || y_q == '0 || piece_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    total_d = CNT_W'(x_q) * CNT_W'(y_q) * CNT_W'(piece_q);
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Read enables only matter here; elsewhere they cannot reach the pipe.
                mismatch = i_rd_en_a ^ i_rd_en_b;
                beat     = i_rd_en_a & i_rd_en_b;
                if (mismatch) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = S_DONE;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == total_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            piece_q    <= '0;
            total_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            x_q        <= x_d;
            y_q        <= y_d;
            piece_q    <= piece_d;
            total_q    <= total_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    add_wb_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_wb_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_beat      (beat),
        .i_flush     (flush),
        .i_load      (accept),
        .i_load_addr (i_addr_o),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_drain_ok  (drain_ok)
    );

    assign o_instr_ready  = (state_q == S_IDLE);
    assign o_start_calc   = (state_q == S_START);
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_err          = err_q;
    assign o_addr_start_a = addr_a_q;
    assign o_addr_start_b = addr_b_q;
    assign o_out_x_length = x_q;
    assign o_out_y_length = y_q;
    assign o_in_piece     = piece_q;

endmodule
